// File: rtl/gsm_pkg.sv
// gsm_pkg -- shared definitions for the 101-tap GSM FIR slice.
//   NTAPS / DW / ACCW        : tap count, sample width, accumulator width
//   sample_t / prod_t / acc_t: 1s17 sample, 2s34 product, 43-bit accumulator
//   H[0..50]                 : unique coefficients, centre tap at index 50
//   coef(k)                  : full 101-tap coefficient via symmetry
package gsm_pkg;

  localparam int unsigned NTAPS = 101;
  localparam int unsigned DW    = 18;
  localparam int unsigned PW    = 2 * DW;
  localparam int unsigned ACCW  = 43;
  localparam int unsigned NUNIQ = 51;

  // Output slice of the accumulator: 2s34 sum -> 1s17 result
  localparam int unsigned OUT_LSB = 17;
  localparam int unsigned OUT_MSB = 34;

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [PW-1:0]   prod_t;
  typedef logic signed [ACCW-1:0] acc_t;

  localparam acc_t ACC_MAX = 43'sd17179869183;   //  2^34 - 1
  localparam acc_t ACC_MIN = -43'sd17179869184;  // -2^34

  localparam sample_t SAT_POS = 18'sd131071;
  localparam sample_t SAT_NEG = -18'sd131072;

  localparam sample_t H [NUNIQ] = '{
     18'sd1000, -18'sd510,  18'sd1040, -18'sd530,  18'sd1080, -18'sd550,
     18'sd1120, -18'sd570,  18'sd1160, -18'sd590,  18'sd1200, -18'sd610,
     18'sd1240, -18'sd630,  18'sd1280, -18'sd650,  18'sd1320, -18'sd670,
     18'sd1360, -18'sd690,  18'sd1400, -18'sd710,  18'sd1440, -18'sd730,
     18'sd1480, -18'sd750,  18'sd1520, -18'sd770,  18'sd1560, -18'sd790,
     18'sd1600, -18'sd810,  18'sd1640, -18'sd830,  18'sd1680, -18'sd850,
     18'sd1720, -18'sd870,  18'sd1760, -18'sd890,  18'sd1800, -18'sd910,
     18'sd1840, -18'sd930,  18'sd1880, -18'sd950,  18'sd1920, -18'sd970,
     18'sd1960, -18'sd990,  18'sd60000
  };

  // h[k] = h[100-k]: taps past the centre mirror back into H
  function automatic sample_t coef(input int unsigned k);
    logic [5:0] idx;
    idx = (k < NUNIQ) ? 6'(k) : 6'(NTAPS - 1 - k);
    return H[idx];
  endfunction

endpackage

// File: rtl/gsm_adder_tree.sv
// gsm_adder_tree -- combinational sum of all tap products.
//   p   : N signed 2s34 products
//   sum : 43-bit signed exact sum (no intermediate truncation)
// Written as a linear reduction; synthesis rebalances it into a tree.
module gsm_adder_tree
  import gsm_pkg::*;
#(
  parameter int unsigned N = 101
) (
  input  prod_t p [N],
  output acc_t  sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = sum + acc_t'(p[i]);
    end
  end

endmodule

// File: rtl/gsm_101_mults.sv
// gsm_101_mults -- direct-form 101-tap FIR, one dedicated multiplier per tap.
//   sys_clk    : system clock, all registers on rising edge
//   reset      : synchronous, active-high; clears delay line, products and y
//   sam_clk_en : sample-rate enable; every register holds while low
//   x_in       : signed 1s17 input sample
//   y          : signed 1s17 filtered output, registered
// Pipeline: delay line -> product registers -> output register, so a sample
// captured at enable n first reaches y after enable n+2.
// Optional build macro GSM_OUT_SAT_EN: clamp y instead of wrapping on overflow.
module gsm_101_mults
  import gsm_pkg::*;
#(
  parameter int unsigned NTAPS = gsm_pkg::NTAPS,
  parameter int unsigned DW    = gsm_pkg::DW
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 sam_clk_en,
  input  logic signed [DW-1:0] x_in,
  output logic signed [DW-1:0] y
);

  sample_t x_dly [NTAPS];
  prod_t   prod  [NTAPS];
  acc_t    acc;
  sample_t y_next;
  logic    acc_unused;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        x_dly[k] <= '0;
        prod[k]  <= '0;
      end
      y <= '0;
    end else if (sam_clk_en) begin
      x_dly[0] <= x_in;
      for (int unsigned k = 1; k < NTAPS; k++) begin
        x_dly[k] <= x_dly[k-1];
      end
      for (int unsigned k = 0; k < NTAPS; k++) begin
        prod[k] <= prod_t'(x_dly[k]) * prod_t'(coef(k));
      end
      y <= y_next;
    end
  end

  gsm_adder_tree #(
    .N (NTAPS)
  ) u_adder_tree (
    .p   (prod),
    .sum (acc)
  );

`ifdef GSM_OUT_SAT_EN
  always_comb begin
    if (acc > ACC_MAX) begin
      y_next = SAT_POS;
    end else if (acc < ACC_MIN) begin
      y_next = SAT_NEG;
    end else begin
      y_next = acc[OUT_MSB:OUT_LSB];
    end
  end
`else
  // Overflow wraps silently: the top accumulator bits are simply dropped
  always_comb begin
    y_next = acc[OUT_MSB:OUT_LSB];
  end
`endif

  // Bits below the output LSB are truncated (floor); guard bits only matter
  // to the saturating build
  assign acc_unused = ^{acc[ACCW-1:OUT_MSB+1], acc[OUT_LSB-1:0]};

endmodule

// File: tb/tb_gsm_101_mults.sv
// tb_gsm_101_mults -- directed self-checking bench for gsm_101_mults.
// Expected outputs come from hand constants and a convolution model over the
// samples captured since the last reset.
module tb_gsm_101_mults;
  import gsm_pkg::*;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               sam_clk_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y;

  int checks = 0;
  int errors = 0;

  longint samp [$];

  always #5 sys_clk = ~sys_clk;

  gsm_101_mults #(
    .NTAPS (101),
    .DW    (18)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .x_in       (x_in),
    .y          (y)
  );

  function automatic longint coef_tb(input int k);
    sample_t h;
    h = H[(k < 51) ? k : 100 - k];
    return longint'(h);
  endfunction

  function automatic logic signed [17:0] to_out(input longint acc);
    logic signed [63:0] a;
    a = acc;
`ifdef GSM_OUT_SAT_EN
    if (acc > 64'sd17179869183) return 18'sd131071;
    if (acc < -64'sd17179869184) return -18'sd131072;
`endif
    return a[34:17];
  endfunction

  // y after the n-th enable since reset reflects samples n-3-k, k = 0..100
  function automatic logic signed [17:0] model_y();
    longint acc;
    int     n;
    acc = 0;
    n   = samp.size();
    for (int k = 0; k < 101; k++) begin
      int j;
      j = n - 3 - k;
      if (j >= 0) acc += coef_tb(k) * samp[j];
    end
    return to_out(acc);
  endfunction

  function automatic logic signed [17:0] impulse_tap(input int k);
    longint p;
    p = 64'sd131071 * coef_tb(k);
    return 18'(p >>> 17);
  endfunction

  task automatic check(input string tag, input logic signed [17:0] obs,
                       input logic signed [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // gap idle cycles (y must hold), then one enable cycle carrying xv
  task automatic en_sample(input logic signed [17:0] xv, input int gap,
                           input string tag);
    for (int i = 0; i < gap; i++) begin
      sam_clk_en = 1'b0;
      x_in       = 18'sd12345;
      @(posedge sys_clk); #1;
      check({tag, "_hold"}, y, model_y());
    end
    sam_clk_en = 1'b1;
    x_in       = xv;
    @(posedge sys_clk); #1;
    samp.push_back(longint'(xv));
    sam_clk_en = 1'b0;
    check(tag, y, model_y());
  endtask

  task automatic do_reset(input int cycles, input logic en,
                          input logic signed [17:0] xv);
    reset      = 1'b1;
    sam_clk_en = en;
    x_in       = xv;
    for (int i = 0; i < cycles; i++) begin
      @(posedge sys_clk); #1;
      samp.delete();
      check("reset_y", y, 18'sd0);
    end
    reset      = 1'b0;
    sam_clk_en = 1'b0;
  endtask

  logic signed [17:0] seq [12] = '{
    18'sd1000, -18'sd2000, 18'sd131071, -18'sd131072, 18'sd5, 18'sd0,
    18'sd70000, -18'sd1, 18'sd65536, -18'sd40000, 18'sd3, 18'sd99999
  };

  initial begin
    reset      = 1'b1;
    sam_clk_en = 1'b0;
    x_in       = '0;

    // Reset clears everything even while enabled with live input
    do_reset(2, 1'b1, 18'sd131071);

    // Impulse: captured on the very edge reset deasserts, 1-in-4 enables
    en_sample(18'sd131071, 0, "imp_in");
    en_sample(18'sd0, 3, "imp_lat");
    check("imp_lat_zero", y, 18'sd0);
    for (int k = 0; k < 101; k++) begin
      en_sample(18'sd0, 3, "imp");
      check("imp_tap", y, impulse_tap(k));
    end
    for (int i = 0; i < 5; i++) begin
      en_sample(18'sd0, 3, "imp_tail");
      check("imp_tail_zero", y, 18'sd0);
    end
    check("imp_h0", impulse_tap(0), 18'sd999);
    check("imp_h50", impulse_tap(50), 18'sd59999);

    // Zero input
    do_reset(1, 1'b0, 18'sd0);
    for (int i = 0; i < 300; i++) begin
      en_sample(18'sd0, 0, "zero");
      check("zero_y", y, 18'sd0);
    end

    // DC step: sum h = 96500, (65536*96500)>>>17 = 48250
    do_reset(1, 1'b0, 18'sd0);
    for (int i = 0; i < 112; i++) begin
      en_sample(18'sd65536, 0, "dc");
      if (i >= 102) check("dc_settled", y, 18'sd48250);
    end

    // Saturation pattern: sign of x matches sign of h on every tap
    do_reset(1, 1'b0, 18'sd0);
    for (int j = 0; j < 101; j++) begin
      en_sample((coef_tb(100 - j) > 0) ? 18'sd131071 : -18'sd131072, 0, "satp");
    end
    en_sample(18'sd0, 0, "satp_flush");
    en_sample(18'sd0, 0, "satp_flush");
`ifdef GSM_OUT_SAT_EN
    check("sat_pos", y, 18'sd131071);
`else
    check("wrap_pos", y, -18'sd90646);
`endif

    do_reset(1, 1'b0, 18'sd0);
    for (int j = 0; j < 101; j++) begin
      en_sample((coef_tb(100 - j) > 0) ? -18'sd131072 : 18'sd131071, 0, "satn");
    end
    en_sample(18'sd0, 0, "satn_flush");
    en_sample(18'sd0, 0, "satn_flush");
`ifdef GSM_OUT_SAT_EN
    check("sat_neg", y, -18'sd131072);
`else
    check("wrap_neg", y, 18'sd90644);
`endif

    // Reset mid-stream at output tap 20
    do_reset(1, 1'b0, 18'sd0);
    en_sample(18'sd131071, 0, "mid_in");
    en_sample(18'sd0, 0, "mid_lat");
    for (int k = 0; k <= 20; k++) begin
      en_sample(18'sd0, 0, "mid");
    end
    check("mid_tap20", y, impulse_tap(20));
    do_reset(2, 1'b1, 18'sd131071);
    for (int i = 0; i < 10; i++) begin
      en_sample(18'sd0, 1, "mid_after");
      check("mid_after_zero", y, 18'sd0);
    end

    // Same sequence: enable held high, then 1-in-4
    do_reset(1, 1'b0, 18'sd0);
    for (int i = 0; i < 12; i++) en_sample(seq[i], 0, "gate_hi");
    for (int i = 0; i < 3; i++) en_sample(18'sd0, 0, "gate_hi_flush");
    do_reset(1, 1'b0, 18'sd0);
    for (int i = 0; i < 12; i++) en_sample(seq[i], 3, "gate_q");
    for (int i = 0; i < 3; i++) en_sample(18'sd0, 3, "gate_q_flush");
    // 1000*h[0] >>> 17 at the third enable: 1000000/131072 -> 7
    do_reset(1, 1'b0, 18'sd0);
    en_sample(18'sd1000, 3, "gate_first");
    en_sample(18'sd0, 3, "gate_first");
    en_sample(18'sd0, 3, "gate_first");
    check("gate_first_val", y, 18'sd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
